time_loader_rpt: RTL and testbench

//  Parametrised time-setting loader for the alarm/clock path. Holds hour/minute/second

---
 rtl/time_pkg.sv | 31 +++
 rtl/time_loader_rpt_if.sv | 38 +++
 rtl/press_repeat.sv | 90 +++++++++
 rtl/time_loader_rpt.sv | 97 +++++++++
 tb/tb_time_loader_rpt.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_pkg.sv
// Shared types and defaults for the time-setting loader.
// Field wrap limits, field select and press FSM encodings.
package time_pkg;

  localparam int HOUR_MAX_DEF = 23;
  localparam int MIN_MAX_DEF  = 59;

  typedef enum logic [1:0] {
    F_NONE,
    F_HOUR,
    F_MIN,
    F_SEC
  } field_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    REPEAT,
    LOCK
  } state_t;

  function automatic logic [5:0] wrap_step(
    input logic [5:0] v,
    input logic [5:0] max,
    input logic       dn
  );
    if (dn) return (v == 6'd0) ? max : v - 6'd1;
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_loader_rpt_if.sv
// Button, preload and time-field bundle of the loader.
// master drives buttons/preload, slave owns the fields.
interface time_loader_rpt_if;

  logic       enable;
  logic       down;
  logic       hour;
  logic       minute;
  logic       second;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       mode_12h;
  logic [4:0] hour_count;
  logic [5:0] min_count;
  logic [5:0] sec_count;
  logic [4:0] disp_hour;
  logic       pm;
  logic       changed;

  modport master (
    output enable, down, hour, minute, second,
    output load, load_hour, load_min, load_sec,
    output mode_12h,
    input  hour_count, min_count, sec_count,
    input  disp_hour, pm, changed
  );

  modport slave (
    input  enable, down, hour, minute, second,
    input  load, load_hour, load_min, load_sec,
    input  mode_12h,
    output hour_count, min_count, sec_count,
    output disp_hour, pm, changed
  );

endinterface

// File: rtl/press_repeat.sv
// Single-button press/hold/auto-repeat timer.
// step_pulse is decided on the edge that samples the press.
module press_repeat
  import time_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES   = 16'd50000,
  parameter logic [15:0] REPEAT_CYCLES = 16'd10000
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   enable,
  input  logic   multi,
  input  field_t field,
  output logic   step_pulse,
  output logic   lock
);

  localparam int TMAX = int'((HOLD_CYCLES > REPEAT_CYCLES)
                             ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_HOLD = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] T_REP  = TW'(REPEAT_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t        state;
  field_t        cur;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          held;

  assign held      = enable && !multi && (field == cur);
  assign timer_inc = (&timer) ? timer : timer + T_ONE;
  assign lock      = (state == LOCK);

  always_comb begin
    step_pulse = 1'b0;
    if (enable && !multi) begin
      unique case (state)
        IDLE:   step_pulse = (field != F_NONE);
        FIRST:  step_pulse = held && (timer == T_HOLD);
        REPEAT: step_pulse = held && (timer == T_REP);
        LOCK:   step_pulse = 1'b0;
      endcase
    end
  end

  // timer holds cycles seen since the last step of the held button
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cur   <= F_NONE;
      timer <= '0;
    end else if (!enable) begin
      state <= IDLE;
      cur   <= F_NONE;
      timer <= '0;
    end else if (multi) begin
      state <= LOCK;
      timer <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (field != F_NONE) begin
            state <= FIRST;
            cur   <= field;
            timer <= T_ONE;
          end
        end
        FIRST, REPEAT: begin
          if (field == F_NONE) begin
            state <= IDLE;
            timer <= '0;
          end else if (field != cur) begin
            state <= LOCK;
            timer <= '0;
          end else if (step_pulse) begin
            state <= REPEAT;
            timer <= T_ONE;
          end else begin
            timer <= timer_inc;
          end
        end
        LOCK: begin
          if (field == F_NONE) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/time_loader_rpt.sv
// Hour/minute/second setting loader with hold-to-repeat,
// parallel preload and a 12/24-hour display view.
module time_loader_rpt
  import time_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES   = 16'd50000,
  parameter logic [15:0] REPEAT_CYCLES = 16'd10000,
  parameter int          HOUR_MAX      = HOUR_MAX_DEF,
  parameter int          MIN_MAX       = MIN_MAX_DEF
) (
  input logic          clock,
  input logic          reset_n,
  time_loader_rpt_if.slave bus
);

  localparam logic [4:0] H_MAX = 5'(HOUR_MAX);
  localparam logic [5:0] M_MAX = 6'(MIN_MAX);

  field_t     field;
  logic       multi;
  logic       step;
  logic       lock;
  logic       step_ok;
  logic [4:0] hour_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic [4:0] disp;

  always_comb begin
    field = F_NONE;
    multi = 1'b0;
    if (bus.enable) begin
      case ({bus.hour, bus.minute, bus.second})
        3'b100:  field = F_HOUR;
        3'b010:  field = F_MIN;
        3'b001:  field = F_SEC;
        3'b000:  field = F_NONE;
        default: multi = 1'b1;
      endcase
    end
  end

  press_repeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_press (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (bus.enable),
    .multi      (multi),
    .field      (field),
    .step_pulse (step),
    .lock       (lock)
  );

  assign step_ok = step && !lock;

  // preload wins over a same-edge step
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      bus.changed <= 1'b0;
    end else begin
      bus.changed <= bus.load || step_ok;
      if (bus.load) begin
        hour_q <= (bus.load_hour > H_MAX) ? H_MAX : bus.load_hour;
        min_q  <= (bus.load_min > M_MAX) ? M_MAX : bus.load_min;
        sec_q  <= (bus.load_sec > M_MAX) ? M_MAX : bus.load_sec;
      end else if (step_ok) begin
        case (field)
          F_HOUR: hour_q <= 5'(wrap_step({1'b0, hour_q},
                                         {1'b0, H_MAX}, bus.down));
          F_MIN:  min_q  <= wrap_step(min_q, M_MAX, bus.down);
          F_SEC:  sec_q  <= wrap_step(sec_q, M_MAX, bus.down);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    disp = hour_q;
    if (bus.mode_12h) begin
      if (hour_q == 5'd0)       disp = 5'd12;
      else if (hour_q > 5'd12)  disp = hour_q - 5'd12;
    end
  end

  assign bus.hour_count = hour_q;
  assign bus.min_count  = min_q;
  assign bus.sec_count  = sec_q;
  assign bus.disp_hour  = disp;
  assign bus.pm         = (hour_q >= 5'd12);

endmodule

// File: tb/tb_time_loader_rpt.sv
// Directed and randomized bench for time_loader_rpt against
// an arithmetic model of press/hold/repeat and wrap behaviour.
module tb_time_loader_rpt;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int HMAX = 23;
  localparam int MMAX = 59;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int mh = 0;
  int mm = 0;
  int ms = 0;
  int pulses;

  time_loader_rpt_if bus ();

  time_loader_rpt #(
    .HOLD_CYCLES   (16'(HOLD)),
    .REPEAT_CYCLES (16'(REP))
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nsteps(input int n);
    if (n == 0) return 0;
    if (n <= HOLD) return 1;
    return 2 + (n - 1 - HOLD) / REP;
  endfunction

  function automatic int wrapv(input int v, input int max,
                               input int dn, input int s);
    int m;
    m = max + 1;
    if (dn != 0) return ((v - s) % m + m) % m;
    return (v + s) % m;
  endfunction

  function automatic int disp12(input int h);
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  function automatic int clampv(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic do_load(input int h, input int m, input int s);
    bus.load_hour = 5'(h);
    bus.load_min  = 6'(m);
    bus.load_sec  = 6'(s);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    mh = clampv(h, HMAX);
    mm = clampv(m, MMAX);
    ms = clampv(s, MMAX);
  endtask

  task automatic btns(input logic h, input logic m, input logic s);
    bus.hour = h;
    bus.minute = m;
    bus.second = s;
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, ".hour"}, int'(bus.hour_count), mh);
    chk({tag, ".min"}, int'(bus.min_count), mm);
    chk({tag, ".sec"}, int'(bus.sec_count), ms);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.down = 1'b0;
    btns(0, 0, 0);
    bus.load = 1'b0;
    bus.load_hour = '0;
    bus.load_min = '0;
    bus.load_sec = '0;
    bus.mode_12h = 1'b1;
    #12;
    chk_fields("reset");
    chk("reset.changed", int'(bus.changed), 0);
    chk("reset.disp12", int'(bus.disp_hour), 12);
    chk("reset.pm", int'(bus.pm), 0);
    rst_n = 1'b1;
    tick();
    bus.enable = 1'b1;

    // short press
    btns(0, 1, 0);
    tick();
    btns(0, 0, 0);
    mm = 1;
    chk("short.min", int'(bus.min_count), 1);
    chk("short.changed", int'(bus.changed), 1);
    tick();
    chk("short.changed_off", int'(bus.changed), 0);

    // hold repeat, 10 cycles
    btns(1, 0, 0);
    pulses = 0;
    repeat (10) begin
      tick();
      pulses += int'(bus.changed);
    end
    btns(0, 0, 0);
    tick();
    mh = 4;
    chk("hold.hour", int'(bus.hour_count), 4);
    chk("hold.pulses", pulses, 4);
    chk("hold.nsteps_model", nsteps(10), 4);

    // wrap
    do_load(23, 59, 59);
    chk_fields("load235959");
    btns(1, 0, 0);
    tick();
    btns(0, 0, 0);
    tick();
    mh = 0;
    chk("wrap.hour_up", int'(bus.hour_count), 0);
    do_load(5, 0, 7);
    bus.down = 1'b1;
    btns(0, 1, 0);
    tick();
    btns(0, 0, 0);
    tick();
    bus.down = 1'b0;
    mm = 59;
    chk("wrap.min_down", int'(bus.min_count), 59);

    // lock
    btns(0, 1, 1);
    tick();
    chk("lock.changed", int'(bus.changed), 0);
    chk_fields("lock.both");
    btns(0, 1, 0);
    tick();
    chk("lock.partial_changed", int'(bus.changed), 0);
    chk_fields("lock.partial");
    btns(0, 0, 0);
    tick();
    btns(0, 0, 1);
    tick();
    btns(0, 0, 0);
    tick();
    ms = wrapv(ms, MMAX, 0, 1);
    chk("lock.sec_after", int'(bus.sec_count), ms);

    // load beats a same-edge step
    btns(1, 0, 0);
    do_load(7, 30, 40);
    btns(0, 0, 0);
    chk("loadpri.changed", int'(bus.changed), 1);
    tick();
    chk_fields("loadpri");

    // clamp
    do_load(31, 63, 60);
    chk_fields("clamp");

    // 12h view
    do_load(12, 0, 0);
    chk("v12.disp", int'(bus.disp_hour), 12);
    chk("v12.pm", int'(bus.pm), 1);
    do_load(13, 0, 0);
    chk("v13.disp", int'(bus.disp_hour), 1);
    chk("v13.pm", int'(bus.pm), 1);
    bus.mode_12h = 1'b0;
    #1;
    chk("v13.disp24", int'(bus.disp_hour), 13);

    // disabled buttons
    bus.enable = 1'b0;
    btns(1, 0, 0);
    repeat (6) tick();
    btns(0, 0, 0);
    chk_fields("disabled");
    bus.enable = 1'b1;
    tick();

    // randomized presses against the model
    for (int t = 0; t < 24; t++) begin
      int f;
      int n;
      int dn;
      int s;
      f = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 12));
      dn = int'($urandom_range(0, 1));
      bus.mode_12h = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        do_load(int'($urandom_range(0, 31)),
                int'($urandom_range(0, 63)),
                int'($urandom_range(0, 63)));
      bus.down = 1'(dn);
      btns(f == 0, f == 1, f == 2);
      pulses = 0;
      repeat (n) begin
        tick();
        pulses += int'(bus.changed);
      end
      btns(0, 0, 0);
      tick();
      s = nsteps(n);
      if (f == 0) mh = wrapv(mh, HMAX, dn, s);
      if (f == 1) mm = wrapv(mm, MMAX, dn, s);
      if (f == 2) ms = wrapv(ms, MMAX, dn, s);
      chk_fields($sformatf("rand%0d", t));
      chk($sformatf("rand%0d.pulses", t), pulses, s);
      chk($sformatf("rand%0d.disp", t), int'(bus.disp_hour),
          bus.mode_12h ? disp12(mh) : mh);
      chk($sformatf("rand%0d.pm", t), int'(bus.pm), int'(mh >= 12));
    end
    bus.down = 1'b0;

    // reset mid-hold
    do_load(5, 5, 5);
    btns(1, 0, 0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    mh = 0;
    mm = 0;
    ms = 0;
    chk_fields("rst_mid");
    btns(0, 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk_fields("rst_after");
    chk("rst_after.changed", int'(bus.changed), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
